flash_dump_sequencer: RTL and testbench

FLASH_DUMP_SEQUENCER -- requirements
Module: flash_dump_sequencer

---
 rtl/flash_dump_sequencer.sv | 130 +++++++++++++
 tb/tb_flash_dump_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_dump_sequencer.sv
// Streams a block of 32-bit words from memory to a UART byte transmitter.
// Each word is read once, then sent as four bytes, least significant byte first.
module flash_dump_sequencer #(
  parameter int WORD_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  input  logic [WORD_CNT_W-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_CNT_W-1:0] words_sent,
  output logic                  mem_read,
  output logic [1:0]            mem_write,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_store,
  output logic                  mem_done,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_load,
  output logic                  uart_start,
  output logic [7:0]            uart_data,
  input  logic                  uart_done,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_TX     = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [WORD_CNT_W-1:0] CNT_ONE = {{(WORD_CNT_W-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [31:0]             cur_addr_q, cur_addr_d;
  logic [WORD_CNT_W-1:0]   remaining_q, remaining_d;
  logic [WORD_CNT_W-1:0]   words_sent_q, words_sent_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [31:0]             word_reg_q, word_reg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      words_sent_q <= '0;
      byte_idx_q   <= '0;
      word_reg_q   <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      words_sent_q <= words_sent_d;
      byte_idx_q   <= byte_idx_d;
      word_reg_q   <= word_reg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    words_sent_d = words_sent_q;
    byte_idx_d   = byte_idx_q;
    word_reg_d   = word_reg_q;
    busy         = 1'b0;
    done         = 1'b0;
    mem_read     = 1'b0;
    mem_addr     = '0;
    mem_done     = 1'b0;
    uart_start   = 1'b0;
    uart_data    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d   = base_addr;
          remaining_d  = word_count;
          words_sent_d = '0;
          state_d      = (word_count != '0) ? S_READ : S_FINISH;
        end
      end
      S_READ: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = cur_addr_q;
        // Acknowledge in the same cycle the data is presented.
        if (mem_ready) begin
          mem_done   = 1'b1;
          word_reg_d = mem_load;
          byte_idx_d = 2'd0;
          state_d    = S_TX;
        end
      end
      S_TX: begin
        busy       = 1'b1;
        uart_start = ~uart_done;
        case (byte_idx_q)
          2'd0:    uart_data = word_reg_q[7:0];
          2'd1:    uart_data = word_reg_q[15:8];
          2'd2:    uart_data = word_reg_q[23:16];
          default: uart_data = word_reg_q[31:24];
        endcase
        if (uart_done) begin
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
          end else begin
            words_sent_d = words_sent_q + CNT_ONE;
            cur_addr_d   = cur_addr_q + 32'd4;
            remaining_d  = remaining_q - CNT_ONE;
            state_d      = (remaining_q == CNT_ONE) ? S_FINISH : S_READ;
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign words_sent  = words_sent_q;
  assign mem_write   = 2'b00;
  assign mem_store   = 32'd0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_flash_dump_sequencer.sv
// Bench for flash_dump_sequencer: memory and UART responders, a byte/address
// scoreboard fed from a word-level reference model, table and random dumps.
module tb_flash_dump_sequencer;
  localparam int W = 16;

  // ---------------- clock / reset block ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [W-1:0]  word_count = '0;
  logic          busy, done, mem_read, mem_done, uart_start;
  logic [W-1:0]  words_sent;
  logic [1:0]    mem_write, dbg_state;
  logic [31:0]   mem_addr, mem_store;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_load = '0;
  logic [7:0]    uart_data;
  logic          uart_done = 1'b0;

  always #5 clk = ~clk;

  flash_dump_sequencer #(.WORD_CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .words_sent(words_sent),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_store(mem_store), .mem_done(mem_done), .mem_ready(mem_ready),
    .mem_load(mem_load), .uart_start(uart_start), .uart_data(uart_data),
    .uart_done(uart_done), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0]   exp_q[$];
  logic [31:0]  addr_q[$];
  logic [7:0]   obs_q[$];
  logic [31:0]  obs_addr_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // responder / monitor state
  logic         s_busy = 0, s_done = 0, s_mem_read = 0, s_mem_done = 0, s_uart_start = 0;
  logic [31:0]  s_mem_addr = '0;
  logic [7:0]   s_uart_data = '0;
  logic [W-1:0] s_words_sent = '0;
  int  mem_lat_g = 3, uart_lat_g = 10;
  int  rd_cnt = 0, u_cnt = 0;
  bit  prev_ready = 0, last_rst = 1;
  bit  inj_start = 0, inj_ready = 0, inj_udone = 0;
  int  bytes_seen = 0, done_cnt = 0, rd_hi = 0, us_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory contents as seen by the bench; one fixed word for the directed cases.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0080_0000) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Reference model: word i of a dump comes from base+4i (mod 2^32), bytes LSB first.
  task automatic load_model(input logic [31:0] base, input logic [W-1:0] cnt);
    logic [31:0] a, d;
    exp_q.delete(); addr_q.delete(); obs_q.delete(); obs_addr_q.delete();
    for (int w = 0; w < int'(cnt); w++) begin
      a = base + 32'(w) * 32'd4;
      d = mem_fn(a);
      addr_q.push_back(a);
      for (int j = 0; j < 4; j++) exp_q.push_back(d[8*j +: 8]);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic rst_v, input logic start_v,
                      input logic [31:0] base_v, input logic [W-1:0] cnt_v);
    bit fire_mem, fire_uart, was_rst, p_mr;
    logic [31:0] p_ma;
    @(negedge clk);
    fire_mem = 0; fire_uart = 0;
    was_rst = last_rst;
    if (rst_v || was_rst) begin
      rd_cnt = 0; u_cnt = 0;
    end else begin
      if (s_mem_read && !prev_ready) begin
        rd_cnt++;
        if (rd_cnt >= mem_lat_g) begin fire_mem = 1; rd_cnt = 0; end
      end
      if (s_uart_start) begin
        u_cnt++;
        if (u_cnt >= uart_lat_g) begin fire_uart = 1; u_cnt = 0; end
      end
    end
    rst = rst_v; start = start_v; base_addr = base_v; word_count = cnt_v;
    if (inj_start) begin start = 1'b1; base_addr = 32'h0BAD_0000; word_count = W'(7); end
    mem_ready = fire_mem | inj_ready;
    mem_load  = fire_mem ? mem_fn(s_mem_addr) : (inj_ready ? 32'hBAD0_BAD0 : 32'h0);
    uart_done = fire_uart | inj_udone;
    prev_ready = fire_mem;
    last_rst = rst_v;
    p_mr = s_mem_read; p_ma = s_mem_addr;
    #1;
    s_busy = busy; s_done = done; s_mem_read = mem_read; s_mem_done = mem_done;
    s_uart_start = uart_start; s_mem_addr = mem_addr; s_uart_data = uart_data;
    s_words_sent = words_sent;
    if (!rst_v) begin
      check("rd_tx_exclusive", 64'(s_mem_read & s_uart_start), 0);
      check("write_consts", {mem_write, mem_store}, 0);
      check("mem_done_rule", 64'(s_mem_done), 64'(s_mem_read & mem_ready));
      if (s_done) check("done_not_busy", 64'(s_busy), 0);
      if (!was_rst && p_mr && s_mem_read) check("addr_stable", s_mem_addr, p_ma);
      if (s_mem_read) rd_hi++;
      if (s_uart_start) us_hi++;
      if (s_done) done_cnt++;
      if (fire_mem) begin
        obs_addr_q.push_back(s_mem_addr);
        check("read_expected", 64'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) check("read_addr", s_mem_addr, addr_q.pop_front());
      end
      if (fire_uart) begin
        bytes_seen++;
        obs_q.push_back(s_uart_data);
        check("byte_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("uart_byte", s_uart_data, exp_q.pop_front());
      end
    end
    inj_start = 0; inj_ready = 0; inj_udone = 0;
  endtask

  // One full dump with latency, count and scoreboard checks.
  task automatic run_dump(input logic [31:0] base, input logic [W-1:0] cnt,
                          input int ml, input int ul, input bit spur,
                          input int exp_done, input logic [W-1:0] exp_words);
    int got_done;
    bit did_s, did_r, did_u;
    got_done = -1; did_s = 0; did_r = 0; did_u = 0;
    mem_lat_g = ml; uart_lat_g = ul;
    load_model(base, cnt);
    done_cnt = 0; bytes_seen = 0; rd_hi = 0; us_hi = 0;
    step(0, 1, base, cnt);
    for (int k = 1; k <= exp_done + 50 && got_done < 0; k++) begin
      if (spur) begin
        if (!did_s && s_uart_start && bytes_seen == 1) begin inj_start = 1; did_s = 1; end
        else if (!did_r && s_uart_start && bytes_seen == 2) begin inj_ready = 1; did_r = 1; end
        else if (!did_u && s_mem_read && rd_cnt == 1) begin inj_udone = 1; did_u = 1; end
      end
      step(0, 0, 32'h0, '0);
      if (k == 1) check("first_cycle_read", 64'(s_mem_read), 64'(cnt != 0));
      if (s_done) got_done = k;
    end
    check("done_latency", 64'(got_done), 64'(exp_done));
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 32'h0, '0);
      check("words_sent_hold", s_words_sent, exp_words);
      check("idle_after_done", {s_busy, s_done}, 0);
    end
    check("done_pulses", done_cnt, 1);
    check("bytes_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    check("read_cycles", rd_hi, 64'(int'(cnt) * (ml + 1)));
    check("uart_start_cycles", us_hi, 64'(int'(cnt) * 4 * ul));
  endtask

  typedef struct {
    logic [31:0]  base;
    logic [W-1:0] cnt;
    int           ml;
    int           ul;
    bit           spur;
    int           exp_done;
    logic [W-1:0] exp_words;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0]  rb;
    logic [W-1:0] rc;
    int           rml, rul;

    vecs[0] = '{32'h0080_0000, W'(1), 3, 10, 0,  49, W'(1)};
    vecs[1] = '{32'h0080_0000, W'(3), 3, 10, 0, 145, W'(3)};
    vecs[2] = '{32'h0000_0010, W'(0), 2,  2, 0,   1, W'(0)};
    vecs[3] = '{32'hFFFF_FFFC, W'(2), 1,  1, 0,  21, W'(2)};
    vecs[4] = '{32'h0000_0100, W'(2), 5,  2, 0,  37, W'(2)};
    vecs[5] = '{32'h0080_0000, W'(1), 3, 10, 1,  49, W'(1)};

    // reset state
    step(1, 0, 32'h0, '0);
    step(1, 1, 32'h1234_5678, W'(5));
    step(0, 0, 32'h0, '0);
    check("rst_ctrl", {s_busy, s_done, s_mem_read, s_mem_done, s_uart_start}, 0);
    check("rst_mem_addr", s_mem_addr, 0);
    check("rst_uart_data", s_uart_data, 0);
    check("rst_words_sent", s_words_sent, 0);
    check("rst_dbg_idle", dbg_state, 0);

    for (int i = 0; i < 6; i++) begin
      run_dump(vecs[i].base, vecs[i].cnt, vecs[i].ml, vecs[i].ul, vecs[i].spur,
               vecs[i].exp_done, vecs[i].exp_words);
      if (i == 0 || i == 5) begin
        check("byte_order", {obs_q[0], obs_q[1], obs_q[2], obs_q[3]}, 32'hEFBE_ADDE);
        check("single_addr", obs_addr_q[0], 32'h0080_0000);
      end
      if (i == 1) check("multi_addrs", {obs_addr_q[1], obs_addr_q[2]}, 64'h0080_0004_0080_0008);
      if (i == 3) check("wrap_addr", obs_addr_q[1], 32'h0000_0000);
    end

    // reset while the third byte of the first word is in flight
    mem_lat_g = 3; uart_lat_g = 10;
    load_model(32'h0080_0000, W'(2));
    bytes_seen = 0;
    step(0, 1, 32'h0080_0000, W'(2));
    for (int k = 0; k < 500 && !(bytes_seen == 2 && s_uart_start); k++) step(0, 0, 32'h0, '0);
    check("mid_reached", bytes_seen, 2);
    step(1, 0, 32'h0, '0);
    step(0, 0, 32'h0, '0);
    check("mid_rst_uart_start", 64'(s_uart_start), 0);
    check("mid_rst_busy", 64'(s_busy), 0);
    check("mid_rst_words", s_words_sent, 0);
    run_dump(32'h0080_0000, W'(1), 3, 10, 0, 49, W'(1));

    // randomized dumps against the model
    for (int r = 0; r < 10; r++) begin
      rb  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4)
                                        : $urandom;
      rc  = W'($urandom_range(0, 4));
      rml = $urandom_range(1, 4);
      rul = $urandom_range(1, 6);
      run_dump(rb, rc, rml, rul, 0, 1 + int'(rc) * ((rml + 1) + 4 * (rul + 1)), rc);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step(0, 0, 32'h0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
